// File: rtl/pkt_frame_fsm.sv
//------------------------------------------------------------------------------
// Module   : pkt_frame_fsm
// Purpose  : Packet-framing state machine for a single head/tail/valid beat
//            stream. Measures packet length, enforces a maximum length,
//            optionally accepts single-beat packets, flags framing violations,
//            counts completed packets and resynchronises on the next head.
// Options  : `define PKT_FRAME_ERRCNT_EN to build the 8-bit saturating
//            violation counter on err_count; otherwise err_count is tied to 0.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pkt_frame_fsm #(
  parameter int LEN_W          = 8,
  parameter int MAX_LEN        = 16,
  parameter int CNT_W          = 16,
  parameter int SINGLE_BEAT_OK = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             head,
  input  logic             tail,
  input  logic             valid,
  output logic [2:0]       state,
  output logic [LEN_W-1:0] pkt_len,
  output logic             pkt_done,
  output logic             err,
  output logic [CNT_W-1:0] pkt_count,
  output logic [7:0]       err_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HEAD = 3'd1,
    S_DATA = 3'd2,
    S_TAIL = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  // Length limit widened by one bit so the overlength compare cannot wrap.
  localparam logic [LEN_W:0] C_MAX_LEN = (LEN_W+1)'(MAX_LEN);

  state_t           r_state;
  state_t           w_next_state;
  logic [LEN_W-1:0] w_next_len;
  logic [LEN_W:0]   w_len_inc;
  logic             w_overlength;

  assign w_len_inc    = {1'b0, pkt_len} + (LEN_W+1)'(1);
  assign w_overlength = (w_len_inc > C_MAX_LEN);
  assign state        = r_state;

  // Next-state and next-length selection; length holds unless a packet starts or grows.
  always_comb begin
    w_next_state = r_state;
    w_next_len   = pkt_len;
    case (r_state)
      S_IDLE, S_TAIL, S_ERR: begin
        if (valid) begin
          if (head) begin
            if (!tail) begin
              w_next_state = S_HEAD;
              w_next_len   = LEN_W'(1);
            end else if (SINGLE_BEAT_OK != 0) begin
              w_next_state = S_TAIL;
              w_next_len   = LEN_W'(1);
            end else begin
              w_next_state = S_ERR;
            end
          end else begin
            // Orphan data/tail: an error everywhere; ERR simply stays put.
            w_next_state = S_ERR;
          end
        end else if (r_state == S_TAIL) begin
          w_next_state = S_IDLE;
        end
      end
      S_HEAD, S_DATA: begin
        if (valid) begin
          if (head) begin
            w_next_state = S_ERR;
          end else if (w_overlength) begin
            w_next_state = S_ERR;
          end else begin
            w_next_len   = w_len_inc[LEN_W-1:0];
            w_next_state = tail ? S_TAIL : S_DATA;
          end
        end
      end
      default: begin
        w_next_state = S_ERR;
      end
    endcase
  end

  // State register plus registered outputs decoded from the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      pkt_len   <= '0;
      pkt_done  <= 1'b0;
      err       <= 1'b0;
      pkt_count <= '0;
    end else begin
      r_state  <= w_next_state;
      pkt_len  <= w_next_len;
      pkt_done <= (w_next_state == S_TAIL);
      err      <= (w_next_state == S_ERR);
      if (w_next_state == S_TAIL) begin
        pkt_count <= pkt_count + CNT_W'(1);
      end
    end
  end

`ifdef PKT_FRAME_ERRCNT_EN
  logic [7:0] r_err_count;

  // Count each entry into ERR from another state, saturating at 255.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_err_count <= 8'd0;
    end else if ((w_next_state == S_ERR) && (r_state != S_ERR) &&
                 (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = 8'd0;
`endif

endmodule

`default_nettype wire
